spi_master_mc: RTL and testbench
================================

SPI_MASTER_MC -- requirements
Module: spi_master_mc

Interface
REQ-001 SHALL have parameter MAX_WIDTH, default 32: maximum transfer length in bits.
REQ-002 SHALL have parameter NUM_CS, default 4: number of chip-select lines.
REQ-003 SHALL have parameter DIV_WIDTH, default 8: width of the SCLK half-period divider.
REQ-004 SHALL have parameter DELAY, default 2: CS-to-SCLK setup and hold, in i_clk cycles.
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock.
REQ-006 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port i_start, input, 1 bit: transfer request.
REQ-008 SHALL have port i_cs_sel, input, $clog2(NUM_CS) bits: target slave index.
REQ-009 SHALL have port i_len, input, $clog2(MAX_WIDTH)+1 bits: bit count.
REQ-010 SHALL have ports i_cpol, i_cpha and i_lsb_first, each input, 1 bit: per-transfer mode.
REQ-011 SHALL have port i_clk_div, input, DIV_WIDTH bits: SCLK half-period in i_clk cycles.
REQ-012 SHALL have port i_mosi_data, input, MAX_WIDTH bits: transmit word, right-justified.
REQ-013 SHALL have port i_miso, input, 1 bit: serial data in.
REQ-014 SHALL have port o_ready, output, 1 bit: the block accepts i_start.
REQ-015 SHALL have port o_miso_data, output, MAX_WIDTH bits: received word, right-justified.
REQ-016 SHALL have port o_valid, output, 1 bit: one-cycle pulse marking o_miso_data updated.
REQ-017 SHALL have port o_err, output, 1 bit: one-cycle pulse marking a rejected request.
REQ-018 SHALL have port o_mosi, output, 1 bit: serial data out.
REQ-019 SHALL have port o_spi_clk, output, 1 bit: SCLK.
REQ-020 SHALL have port o_cs, output, NUM_CS bits: chip selects, active-low.
REQ-021 SHALL have port o_spi_state, output, 3 bits: current state, for debug.

Function
REQ-022 SHALL accept a request on the rising edge where i_start=1 and o_ready=1; i_start SHALL be ignored at all other times.
REQ-023 SHALL latch all configuration and data inputs at acceptance; input changes during a transfer SHALL have no effect.
REQ-024 SHALL implement states IDLE(0), DELAY_1(1), RUN(2), DELAY_2(3), DONE(4).
REQ-025 SHALL follow transitions: IDLE->DELAY_1 on accept; DELAY_1->RUN after DELAY cycles; RUN->DELAY_2 after the last SCLK edge; DELAY_2->DONE after DELAY cycles; DONE->IDLE unconditionally after 1 cycle.
REQ-026 SHALL drive o_ready=1 only in IDLE.
REQ-027 SHALL drive o_cs[sel]=0 in DELAY_1, RUN and DELAY_2; all other CS bits SHALL be 1, and all CS bits SHALL be 1 in IDLE and DONE.
REQ-028 SHALL make each SCLK half-period max(i_clk_div,1) i_clk cycles, so i_clk_div=0 behaves as 1.
REQ-029 SHALL generate exactly 2*len SCLK edges in RUN.
REQ-030 SHALL hold o_spi_clk at the latched CPOL outside RUN; in IDLE it SHALL track i_cpol, registered.
REQ-031 SHALL, with CPHA=0: present the first bit on o_mosi at RUN entry, sample i_miso on leading edges, and shift o_mosi on trailing edges.
REQ-032 SHALL, with CPHA=1: shift o_mosi on leading edges and sample i_miso on trailing edges; the first bit SHALL appear at the first leading edge.
REQ-033 SHALL, with i_lsb_first=0, transmit i_mosi_data[len-1] first and receive into bit len-1 first; i_lsb_first=1 SHALL transmit bit 0 first and receive into bit 0 first.
REQ-034 SHALL load o_miso_data in DONE with received bits in [len-1:0] and bits above len-1 set to 0; o_miso_data SHALL be held otherwise.
REQ-035 SHALL assert o_valid only in DONE.
REQ-036 SHALL make accept-to-o_valid latency exactly 2*DELAY + 2*len*max(div,1) + 1 cycles.
REQ-037 SHALL drive o_mosi=0 whenever no CS is asserted.
REQ-038 SHALL reject a request when i_len=0, i_len>MAX_WIDTH, or i_cs_sel>=NUM_CS: o_err=1 on the next cycle, state stays IDLE, no CS asserted, and o_miso_data is unchanged.
REQ-039 SHALL, on i_start held high continuously, start the next transfer on the first cycle back in IDLE (back-to-back operation).

Reset
REQ-040 SHALL, on any rising edge with i_rst=1 (including mid-transfer), set state=IDLE, o_cs all 1, o_spi_clk=0, o_mosi=0, o_miso_data=0, o_valid=0, o_err=0, o_ready=1 on the following cycle, and clear all counters and shift registers.

Verification
REQ-041 SHALL verify: mode 0, len=8, div=2, sel=1, MSB-first, mosi=0xA5, slave returns 0x3C -> o_cs=4'b1101 during the transfer, 8 rising SCLK edges, o_mosi sequence 1,0,1,0,0,1,0,1, o_miso_data=0x0000003C, o_valid at cycle 37 after accept.
REQ-042 SHALL verify: modes 1, 2 and 3, each with len=16, mosi=0x1234, loopback (i_miso tied to o_mosi) -> o_miso_data=0x1234 in every mode, with idle SCLK level equal to CPOL.
REQ-043 SHALL verify: LSB-first, len=5, mosi=0x13, loopback -> o_mosi sequence 1,1,0,0,1 and o_miso_data=0x13.
REQ-044 SHALL verify: len=0, then sel=NUM_CS, then len=MAX_WIDTH+1 -> one o_err pulse each, o_cs stays all 1, no SCLK toggles.
REQ-045 SHALL verify: i_rst asserted at the 10th RUN cycle -> next cycle state=0, o_cs all 1, o_spi_clk=0, o_miso_data=0; a following normal transfer completes correctly.
REQ-046 SHALL verify: i_start held high for 3 transfers with div=0 -> three o_valid pulses, each spaced 2*DELAY+2*len+2 cycles apart, with no CS overlap between transfers.

Source files
------------

// File: rtl/spi_master_mc.sv
// spi_master_mc: multi-chip-select SPI master with per-transfer mode.
//
// A request is taken when i_start is high while o_ready is high. All
// configuration and the transmit word are latched at that point. One
// transfer runs DELAY_1 (CS setup), RUN (2*len SCLK edges), DELAY_2
// (CS hold) and DONE (o_valid pulse, o_miso_data update). Illegal
// requests (len 0, len > MAX_WIDTH, cs_sel >= NUM_CS) give a one-cycle
// o_err pulse and leave the block idle.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start             transfer request
//   i_cs_sel            target slave index
//   i_len               bit count, 1..MAX_WIDTH
//   i_cpol/i_cpha       SPI mode
//   i_lsb_first         bit order
//   i_clk_div           SCLK half-period in i_clk cycles (0 acts as 1)
//   i_mosi_data         transmit word, right-justified
//   i_miso              serial data in
//   o_ready             idle, i_start will be accepted
//   o_miso_data         received word, right-justified, zero above len
//   o_valid             one-cycle pulse: o_miso_data updated
//   o_err               one-cycle pulse: request rejected
//   o_mosi, o_spi_clk   serial data out, SCLK
//   o_cs                active-low chip selects
//   o_spi_state         current state (debug)
//
// DELAY must be at least 1.

module spi_master_mc #(
  parameter int MAX_WIDTH = 32,
  parameter int NUM_CS    = 4,
  parameter int DIV_WIDTH = 8,
  parameter int DELAY     = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic [$clog2(NUM_CS)-1:0]  i_cs_sel,
  input  logic [$clog2(MAX_WIDTH):0] i_len,
  input  logic                       i_cpol,
  input  logic                       i_cpha,
  input  logic                       i_lsb_first,
  input  logic [DIV_WIDTH-1:0]       i_clk_div,
  input  logic [MAX_WIDTH-1:0]       i_mosi_data,
  input  logic                       i_miso,
  output logic                       o_ready,
  output logic [MAX_WIDTH-1:0]       o_miso_data,
  output logic                       o_valid,
  output logic                       o_err,
  output logic                       o_mosi,
  output logic                       o_spi_clk,
  output logic [NUM_CS-1:0]          o_cs,
  output logic [2:0]                 o_spi_state
);

  localparam int SW = $clog2(NUM_CS);
  localparam int LW = $clog2(MAX_WIDTH) + 1;
  localparam int IW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int EW = LW + 1;
  localparam int DW = $clog2(DELAY + 1);

  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_WIDTH);
  localparam logic [SW:0]   CS_CNT  = (SW+1)'(NUM_CS);
  localparam logic [LW-1:0] ONE_L   = LW'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DLY1 = 3'd1,
    S_RUN  = 3'd2,
    S_DLY2 = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state_q, state_d;

  // latched request
  logic [SW-1:0]        sel_q;
  logic [LW-1:0]        len_q;
  logic                 cpha_q;
  logic                 lsb_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [MAX_WIDTH-1:0] tx_q;

  // progress
  logic [DW-1:0]        dly_cnt;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [EW-1:0]        edge_cnt;
  logic [LW-1:0]        tx_idx;
  logic [LW-1:0]        rx_idx;
  logic [MAX_WIDTH-1:0] rx_q;
  logic [MAX_WIDTH-1:0] miso_q;
  logic                 sclk_q;
  logic                 mosi_q;
  logic                 err_q;

  logic                 req_bad, accept, reject;
  logic                 dly_done, sclk_tick, last_edge, do_sample;
  logic [IW-1:0]        tx_pos, rx_pos;
  logic                 cs_act;
  logic [NUM_CS-1:0]    cs_n;

  assign req_bad = (i_len == '0) || (i_len > LEN_MAX) ||
                   ({1'b0, i_cs_sel} >= CS_CNT);

  assign dly_done  = ((state_q == S_DLY1) || (state_q == S_DLY2)) &&
                     (dly_cnt == DW'(DELAY - 1));
  assign sclk_tick = (state_q == S_RUN) && (div_cnt == div_q - DIV_WIDTH'(1));
  assign last_edge = sclk_tick && (edge_cnt == {len_q, 1'b0} - EW'(1));

  // Even edge_cnt before the toggle means this is a leading edge.
  // CPHA=0 samples on leading edges, CPHA=1 on trailing ones.
  assign do_sample = (~edge_cnt[0]) ^ cpha_q;

  // Bit position for the next transmitted / received bit.
  assign tx_pos = lsb_q ? tx_idx[IW-1:0] : IW'(len_q - ONE_L - tx_idx);
  assign rx_pos = lsb_q ? rx_idx[IW-1:0] : IW'(len_q - ONE_L - rx_idx);

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    o_ready = 1'b0;
    o_valid = 1'b0;
    cs_act  = 1'b0;
    cs_n    = '1;
    case (state_q)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_start) begin
          if (req_bad) begin
            reject = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = S_DLY1;
          end
        end
      end
      S_DLY1: begin
        cs_act = 1'b1;
        if (dly_done) state_d = S_RUN;
      end
      S_RUN: begin
        cs_act = 1'b1;
        if (last_edge) state_d = S_DLY2;
      end
      S_DLY2: begin
        cs_act = 1'b1;
        if (dly_done) state_d = S_DONE;
      end
      S_DONE: begin
        o_valid = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (cs_act) cs_n[sel_q] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sel_q    <= '0;
      len_q    <= '0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      div_q    <= '0;
      tx_q     <= '0;
      dly_cnt  <= '0;
      div_cnt  <= '0;
      edge_cnt <= '0;
      tx_idx   <= '0;
      rx_idx   <= '0;
      rx_q     <= '0;
      miso_q   <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= reject;

      if (dly_done || !((state_q == S_DLY1) || (state_q == S_DLY2)))
        dly_cnt <= '0;
      else
        dly_cnt <= dly_cnt + DW'(1);

      case (state_q)
        S_IDLE: begin
          // Idle SCLK follows i_cpol so the level is right before CS drops.
          sclk_q <= i_cpol;
          mosi_q <= 1'b0;
          if (accept) begin
            sel_q    <= i_cs_sel;
            len_q    <= i_len;
            cpha_q   <= i_cpha;
            lsb_q    <= i_lsb_first;
            div_q    <= (i_clk_div == '0) ? DIV_WIDTH'(1) : i_clk_div;
            tx_q     <= i_mosi_data;
            rx_q     <= '0;
            div_cnt  <= '0;
            edge_cnt <= '0;
            tx_idx   <= '0;
            rx_idx   <= '0;
          end
        end
        S_DLY1: begin
          // CPHA=0 needs the first bit on the wire before the first edge.
          if (dly_done && !cpha_q) begin
            mosi_q <= tx_q[tx_pos];
            tx_idx <= tx_idx + ONE_L;
          end
        end
        S_RUN: begin
          if (sclk_tick) begin
            div_cnt  <= '0;
            sclk_q   <= ~sclk_q;
            edge_cnt <= edge_cnt + EW'(1);
            if (do_sample) begin
              rx_q[rx_pos] <= i_miso;
              rx_idx       <= rx_idx + ONE_L;
            end else if (tx_idx < len_q) begin
              mosi_q <= tx_q[tx_pos];
              tx_idx <= tx_idx + ONE_L;
            end
          end else begin
            div_cnt <= div_cnt + DIV_WIDTH'(1);
          end
        end
        S_DLY2: begin
          if (dly_done) begin
            miso_q <= rx_q;
            mosi_q <= 1'b0;
          end
        end
        default: mosi_q <= 1'b0;
      endcase
    end
  end

  assign o_miso_data = miso_q;
  assign o_err       = err_q;
  assign o_mosi      = mosi_q & cs_act;
  assign o_spi_clk   = sclk_q;
  assign o_cs        = cs_n;
  assign o_spi_state = state_q;

endmodule

// File: tb/tb_spi_master_mc.sv
// Self-checking bench for spi_master_mc. A second instance with NUM_CS=3
// shares all inputs so that an out-of-range chip select is expressible.
// Expected values come from SPI rules: bit order from data and len,
// sampling edges from CPOL/CPHA, latency from the timing formula.

module tb_spi_master_mc;

  localparam int DLY = 2;

  logic        i_clk, i_rst, i_start;
  logic [1:0]  i_cs_sel;
  logic [5:0]  i_len;
  logic        i_cpol, i_cpha, i_lsb_first;
  logic [7:0]  i_clk_div;
  logic [31:0] i_mosi_data;
  logic        i_miso;

  logic        o_ready, o_valid, o_err, o_mosi, o_spi_clk;
  logic [31:0] o_miso_data;
  logic [3:0]  o_cs;
  logic [2:0]  o_spi_state;

  logic        d3_ready, d3_valid, d3_err, d3_mosi, d3_sclk;
  logic [31:0] d3_data;
  logic [2:0]  d3_cs;
  logic [2:0]  d3_state;

  bit          loopback;
  logic        slave_miso;
  logic [31:0] last_exp;
  int          errors, checks;

  assign i_miso = loopback ? o_mosi : slave_miso;

  spi_master_mc #(.MAX_WIDTH(32), .NUM_CS(4), .DIV_WIDTH(8), .DELAY(DLY)) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_cs_sel(i_cs_sel),
    .i_len(i_len), .i_cpol(i_cpol), .i_cpha(i_cpha), .i_lsb_first(i_lsb_first),
    .i_clk_div(i_clk_div), .i_mosi_data(i_mosi_data), .i_miso(i_miso),
    .o_ready(o_ready), .o_miso_data(o_miso_data), .o_valid(o_valid), .o_err(o_err),
    .o_mosi(o_mosi), .o_spi_clk(o_spi_clk), .o_cs(o_cs), .o_spi_state(o_spi_state)
  );

  spi_master_mc #(.MAX_WIDTH(32), .NUM_CS(3), .DIV_WIDTH(8), .DELAY(DLY)) u_dut3 (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_cs_sel(i_cs_sel),
    .i_len(i_len), .i_cpol(i_cpol), .i_cpha(i_cpha), .i_lsb_first(i_lsb_first),
    .i_clk_div(i_clk_div), .i_mosi_data(i_mosi_data), .i_miso(i_miso),
    .o_ready(d3_ready), .o_miso_data(d3_data), .o_valid(d3_valid), .o_err(d3_err),
    .o_mosi(d3_mosi), .o_spi_clk(d3_sclk), .o_cs(d3_cs), .o_spi_state(d3_state)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transfer, observed from the pins; called at a negedge in IDLE.
  task automatic xfer(input logic [1:0] sel, input int len, input logic cpol,
                      input logic cpha, input logic lsb, input int div,
                      input logic [31:0] data, input logic [31:0] sval,
                      input bit lb, input string tag);
    logic [31:0] mask, exp_rx;
    logic [63:0] seq, exp_seq;
    logic [3:0]  cs_exp;
    logic        prev;
    int          nseq, nrise, k, lat, ediv;
    bit          cs_ok, seen;
    mask    = (len >= 32) ? 32'hFFFF_FFFF : ((32'd1 << len) - 32'd1);
    exp_rx  = (lb ? data : sval) & mask;
    exp_seq = '0;
    for (int i = 0; i < len; i++)
      exp_seq = {exp_seq[62:0], (lsb ? data[i] : data[len-1-i])};
    cs_exp  = ~(4'b0001 << sel);
    ediv    = (div == 0) ? 1 : div;

    chk({tag, " ready"}, 64'(o_ready), 64'd1);
    loopback    = lb;
    k           = 0;
    slave_miso  = lsb ? sval[0] : sval[len-1];
    i_cs_sel    = sel;
    i_len       = 6'(len);
    i_cpol      = cpol;
    i_cpha      = cpha;
    i_lsb_first = lsb;
    i_clk_div   = 8'(div);
    i_mosi_data = data;
    i_start     = 1'b1;

    prev = cpol; nseq = 0; nrise = 0; seq = '0; cs_ok = 1; seen = 0; lat = 0;
    for (int t = 1; t <= 4000 && !seen; t++) begin
      @(negedge i_clk);
      if (t == 1) begin
        // changes after acceptance must not disturb the transfer
        i_start     = 1'b0;
        i_mosi_data = $urandom;
        i_len       = 6'($urandom_range(0, 40));
        i_cpol      = ~cpol;
        i_cpha      = ~cpha;
        i_lsb_first = ~lsb;
        i_clk_div   = 8'($urandom_range(0, 9));
        i_cs_sel    = 2'($urandom);
      end
      if (o_spi_clk !== prev) begin
        if (o_spi_clk === 1'b1) nrise++;
        if ((o_spi_clk !== cpol) ^ cpha) begin
          seq = {seq[62:0], o_mosi};
          nseq++;
          k++;
          if (k < len) slave_miso = lsb ? sval[k] : sval[len-1-k];
        end
        prev = o_spi_clk;
      end
      if (o_valid === 1'b1) begin
        seen = 1;
        lat  = t;
      end else if (o_cs !== cs_exp) begin
        cs_ok = 0;
      end
    end

    chk({tag, " latency"}, 64'(lat), 64'(2*DLY + 2*len*ediv + 1));
    chk({tag, " sclk rises"}, 64'(nrise), 64'(len));
    chk({tag, " mosi bits"}, 64'(nseq), 64'(len));
    chk({tag, " mosi seq"}, seq, exp_seq);
    chk({tag, " miso data"}, 64'(o_miso_data), 64'(exp_rx));
    chk({tag, " cs active"}, 64'(cs_ok), 64'd1);
    chk({tag, " cs done"}, 64'(o_cs), 64'hF);
    chk({tag, " sclk idle"}, 64'(o_spi_clk), 64'(cpol));
    chk({tag, " mosi done"}, 64'(o_mosi), 64'd0);
    last_exp = exp_rx;
    i_cpol   = cpol;
    @(negedge i_clk);
  endtask

  // Illegal request: error pulse, nothing else moves.
  task automatic reject(input int len, input logic [1:0] sel, input bit use3,
                        input string tag);
    i_cpol  = 1'b0;
    i_start = 1'b0;
    @(negedge i_clk);
    i_len       = 6'(len);
    i_cs_sel    = sel;
    i_clk_div   = 8'd1;
    i_cpha      = 1'b0;
    i_lsb_first = 1'b0;
    i_mosi_data = $urandom;
    i_start     = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    chk({tag, " err"},   64'(use3 ? d3_err : o_err), 64'd1);
    chk({tag, " state"}, use3 ? 64'(d3_state) : 64'(o_spi_state), 64'd0);
    chk({tag, " cs"},    use3 ? 64'(d3_cs) : 64'(o_cs), use3 ? 64'h7 : 64'hF);
    chk({tag, " sclk"},  64'(use3 ? d3_sclk : o_spi_clk), 64'd0);
    @(negedge i_clk);
    chk({tag, " pulse"}, 64'(use3 ? d3_err : o_err), 64'd0);
    chk({tag, " sclk2"}, 64'(use3 ? d3_sclk : o_spi_clk), 64'd0);
    chk({tag, " cs2"},   use3 ? 64'(d3_cs) : 64'(o_cs), use3 ? 64'h7 : 64'hF);
    chk({tag, " data"},  use3 ? 64'(d3_data) : 64'(o_miso_data), 64'(last_exp));
  endtask

  initial begin
    int          n, nv, lenr;
    int          vt[3];
    bit          got;
    logic [31:0] d;
    errors = 0; checks = 0; loopback = 0; slave_miso = 1'b0; last_exp = '0;
    i_rst = 1'b1; i_start = 1'b0; i_cs_sel = '0; i_len = '0; i_cpol = 1'b0;
    i_cpha = 1'b0; i_lsb_first = 1'b0; i_clk_div = '0; i_mosi_data = '0;

    // reset state
    repeat (3) @(negedge i_clk);
    chk("rst state", 64'(o_spi_state), 64'd0);
    chk("rst cs", 64'(o_cs), 64'hF);
    chk("rst pins", 64'({o_spi_clk, o_mosi, o_valid, o_err}), 64'd0);
    chk("rst data", 64'(o_miso_data), 64'd0);
    chk("rst ready", 64'(o_ready), 64'd1);
    i_rst = 1'b0;
    @(negedge i_clk);

    // mode 0 against a slave returning 0x3C
    xfer(2'd1, 8, 1'b0, 1'b0, 1'b0, 2, 32'hA5, 32'h3C, 0, "m0");

    // modes 1..3 loopback
    for (int m = 1; m < 4; m++)
      xfer(2'($urandom_range(0, 2)), 16, m[1], m[0], 1'b0, $urandom_range(0, 3),
           32'h1234, 32'h0, 1, $sformatf("mode%0d", m));

    // LSB first
    xfer(2'd0, 5, 1'b0, 1'b0, 1'b1, 1, 32'h13, 32'h0, 1, "lsb");

    // random transfers, data bits above len are don't-care on the wire
    for (int r = 0; r < 3; r++) begin
      lenr = (r == 0) ? 32 : $urandom_range(1, 32);
      xfer(2'($urandom_range(0, 2)), lenr, 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 3), $urandom, $urandom, 1, $sformatf("rand%0d", r));
    end
    xfer(2'd2, 12, 1'b1, 1'b1, 1'b0, 1, 32'h0, 32'h0A5C, 0, "slave m3");

    // rejects
    reject(0, 2'd0, 0, "len0");
    reject(33, 2'd1, 0, "len33");
    loopback = 1;
    reject(4, 2'd3, 1, "sel3");
    // the 4-CS instance legally accepted sel=3; let it finish
    got = 0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge i_clk);
      if (o_valid === 1'b1) got = 1;
    end
    chk("sel3 dut4 done", 64'(got), 64'd1);
    chk("sel3 dut4 data", 64'(o_miso_data), 64'(i_mosi_data & 32'hF));
    last_exp = i_mosi_data & 32'hF;
    @(negedge i_clk);

    // reset at the 10th RUN cycle
    loopback = 1; i_cs_sel = 2'd2; i_len = 6'd16; i_cpol = 1'b0; i_cpha = 1'b0;
    i_lsb_first = 1'b0; i_clk_div = 8'd2; i_mosi_data = $urandom; i_start = 1'b1;
    n = 0;
    for (int c = 0; c < 200 && n < 10; c++) begin
      @(negedge i_clk);
      i_start = 1'b0;
      if (o_spi_state == 3'd2) n++;
    end
    chk("mid run reached", 64'(n), 64'd10);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("mid rst state", 64'(o_spi_state), 64'd0);
    chk("mid rst cs", 64'(o_cs), 64'hF);
    chk("mid rst sclk", 64'(o_spi_clk), 64'd0);
    chk("mid rst data", 64'(o_miso_data), 64'd0);
    chk("mid rst ready", 64'(o_ready), 64'd1);
    last_exp = '0;
    @(negedge i_clk);
    xfer(2'd3, 10, 1'b0, 1'b1, 1'b1, 2, $urandom, 32'h0, 1, "post rst");

    // back-to-back with i_start held, div=0
    d = $urandom;
    loopback = 1; i_cs_sel = 2'd0; i_len = 6'd6; i_cpol = 1'b0; i_cpha = 1'b0;
    i_lsb_first = 1'b0; i_clk_div = 8'd0; i_mosi_data = d; i_start = 1'b1;
    nv = 0; vt[0] = 0; vt[1] = 0; vt[2] = 0;
    for (int c = 0; c < 500 && nv < 3; c++) begin
      @(negedge i_clk);
      if (nv > 0 && c == vt[nv-1] + 1) begin
        chk("b2b cs gap", 64'(o_cs), 64'hF);
        chk("b2b ready", 64'(o_ready), 64'd1);
      end
      if (o_valid === 1'b1) begin
        vt[nv] = c;
        chk($sformatf("b2b data%0d", nv), 64'(o_miso_data), 64'(d & 32'h3F));
        chk($sformatf("b2b cs%0d", nv), 64'(o_cs), 64'hF);
        nv++;
        if (nv == 3) i_start = 1'b0;
      end
    end
    chk("b2b pulses", 64'(nv), 64'd3);
    chk("b2b spacing1", 64'(vt[1] - vt[0]), 64'(2*DLY + 2*6 + 2));
    chk("b2b spacing2", 64'(vt[2] - vt[1]), 64'(2*DLY + 2*6 + 2));
    repeat (3) @(negedge i_clk);
    chk("b2b stopped", 64'(o_spi_state), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
